// File: rtl/tilemap_scheduler.sv
// Walks a MAP_COLS x MAP_ROWS tile map in row-major order and grants the tile renderer
// a TILE_CYCLES window per non-empty map entry, driving its base address, origin and restart.
module tilemap_scheduler #(
  parameter int          MAP_COLS    = 20,
  parameter int          MAP_ROWS    = 15,
  parameter int          MAP_AW      = 9,
  parameter int          TILE_CYCLES = 4096,
  parameter logic [7:0]  SKIP_IDX    = 8'hFF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [MAP_AW-1:0] map_addr,
  input  logic [7:0]        map_data,
  output logic [18:0]       tile_addr,
  output logic [9:0]        top,
  output logic [9:0]        left,
  output logic              tile_rstn,
  output logic              render_active
);

  localparam int COL_W = (MAP_COLS > 1) ? $clog2(MAP_COLS) : 1;
  localparam int ROW_W = (MAP_ROWS > 1) ? $clog2(MAP_ROWS) : 1;
  localparam int CNT_W = (TILE_CYCLES > 1) ? $clog2(TILE_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    WAIT    = 3'd2,
    LOAD    = 3'd3,
    RENDER  = 3'd4,
    ADVANCE = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [CNT_W-1:0] cnt;

  logic last_col;
  logic last_row;
  logic cnt_last;
  logic skip;

  assign last_col = (col == COL_W'(MAP_COLS - 1));
  assign last_row = (row == ROW_W'(MAP_ROWS - 1));
  assign cnt_last = (cnt == CNT_W'(TILE_CYCLES - 1));
  assign skip     = (map_data == SKIP_IDX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   state_nxt = WAIT;
      WAIT:    state_nxt = LOAD;
      LOAD:    state_nxt = skip ? ADVANCE : RENDER;
      RENDER:  if (cnt_last) state_nxt = ADVANCE;
      ADVANCE: state_nxt = (last_col && last_row) ? DONE : FETCH;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Restart/active are registered from the next state so they are high exactly in RENDER.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      map_addr      <= '0;
      tile_addr     <= '0;
      top           <= '0;
      left          <= '0;
      tile_rstn     <= 1'b0;
      render_active <= 1'b0;
      col           <= '0;
      row           <= '0;
      cnt           <= '0;
    end else begin
      done          <= (state_nxt == DONE);
      tile_rstn     <= (state_nxt == RENDER);
      render_active <= (state_nxt == RENDER);
      case (state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            col      <= '0;
            row      <= '0;
            map_addr <= '0;
          end
        end
        LOAD: begin
          if (!skip) begin
            tile_addr <= {1'b0, map_data, 10'b0};
            top       <= 10'(row) << 5;
            left      <= 10'(col) << 5;
            cnt       <= '0;
          end
        end
        RENDER: begin
          cnt <= cnt + CNT_W'(1);
        end
        ADVANCE: begin
          // Row-major walk: the next map index is always the current one plus one.
          if (!(last_col && last_row)) begin
            map_addr <= map_addr + MAP_AW'(1);
            if (last_col) begin
              col <= '0;
              row <= row + ROW_W'(1);
            end else begin
              col <= col + COL_W'(1);
            end
          end
        end
        DONE: begin
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tilemap_scheduler.sv
// Scoreboard bench for tilemap_scheduler on a 2x2 map with 8-cycle tiles: a map model
// predicts every render window and done time, a monitor checks what the DUT presents.
module tb_tilemap_scheduler;

  localparam int C  = 2;
  localparam int R  = 2;
  localparam int AW = 2;
  localparam int TC = 8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic          busy;
  logic          done;
  logic [AW-1:0] map_addr;
  logic [7:0]    map_data;
  logic [18:0]   tile_addr;
  logic [9:0]    top;
  logic [9:0]    left;
  logic          tile_rstn;
  logic          render_active;

  logic [7:0] map_mem [0:C*R-1];

  tilemap_scheduler #(
    .MAP_COLS(C), .MAP_ROWS(R), .MAP_AW(AW), .TILE_CYCLES(TC), .SKIP_IDX(8'hFF)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done),
    .map_addr(map_addr), .map_data(map_data), .tile_addr(tile_addr),
    .top(top), .left(left), .tile_rstn(tile_rstn), .render_active(render_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) map_data <= map_mem[map_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint ta;
    longint top;
    longint left;
    longint idx;
  } tile_t;

  tile_t  exp_q[$];
  longint done_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: every non-empty cell in row-major order becomes one window of TC cycles.
  task automatic model(output int lat);
    int nr;
    int ns;
    tile_t t;
    nr = 0;
    ns = 0;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C; c++) begin
        if (map_mem[r*C + c] == 8'hFF) begin
          ns++;
        end else begin
          nr++;
          t.ta   = longint'(map_mem[r*C + c]) * 1024;
          t.top  = r * 32;
          t.left = c * 32;
          t.idx  = r * C + c;
          exp_q.push_back(t);
        end
      end
    end
    lat = 1 + nr * (4 + TC) + ns * 4;
  endtask

  // Monitor: compares each render window and each done pulse against the queues.
  tile_t cur;
  bit    in_win = 0;
  bit    stable = 1;
  int    win_len = 0;

  always @(negedge clk) begin
    if (!rstn) begin
      in_win = 0;
    end else begin
      if (render_active && !in_win) begin
        in_win  = 1;
        win_len = 1;
        stable  = 1;
        if (exp_q.size() == 0) begin
          chk("tile_unexpected", tile_addr, -1);
          cur.ta = tile_addr; cur.top = top; cur.left = left; cur.idx = map_addr;
        end else begin
          cur = exp_q.pop_front();
          chk("tile_addr", tile_addr, cur.ta);
          chk("top", top, cur.top);
          chk("left", left, cur.left);
          chk("map_addr", map_addr, cur.idx);
          chk("tile_rstn_on", tile_rstn, 1);
        end
      end else if (render_active && in_win) begin
        win_len++;
        if (tile_addr != cur.ta || top != cur.top || left != cur.left || tile_rstn !== 1'b1)
          stable = 0;
      end else if (!render_active && in_win) begin
        in_win = 0;
        chk("window_len", win_len, TC);
        chk("hold_stable", stable, 1);
        chk("tile_rstn_off", tile_rstn, 0);
      end
      if (done) begin
        if (done_q.size() == 0) chk("done_unexpected", cyc, -1);
        else                    chk("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  // Caller is positioned just after a negedge with the DUT idle.
  task automatic run_frame(input bit noise, input bit coincident);
    int lat;
    bit got;
    model(lat);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    done_q.push_back(cyc + lat - 1);
    chk("busy_after_start", busy, 1);
    got = 0;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        got = 1;
        break;
      end
      if (noise && $urandom_range(0, 3) == 0) start = 1'b1;
    end
    if (!got) begin
      chk("done_timeout", 0, 1);
      exp_q.delete();
      done_q.delete();
    end
    if (coincident) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_done", busy, 0);
    chk("done_single", done, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_map_addr"}, map_addr, 0);
    chk({tag, "_tile_addr"}, tile_addr, 0);
    chk({tag, "_top"}, top, 0);
    chk({tag, "_left"}, left, 0);
    chk({tag, "_tile_rstn"}, tile_rstn, 0);
    chk({tag, "_render_active"}, render_active, 0);
  endtask

  initial begin
    int lat;
    bit seen;
    start = 1'b0;
    rstn  = 1'b1;
    for (int i = 0; i < C*R; i++) map_mem[i] = 8'h00;
    #1 rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_start_busy", busy, 0);

    // Directed map {3,5,7,9}
    map_mem[0] = 8'd3; map_mem[1] = 8'd5; map_mem[2] = 8'd7; map_mem[3] = 8'd9;
    run_frame(0, 0);

    // Empty cell at index 1, with start noise while busy and a start in the done cycle
    map_mem[1] = 8'hFF;
    run_frame(1, 1);

    // Back-to-back: starts in the first idle cycle after the previous frame
    map_mem[1] = 8'd5;
    run_frame(0, 0);
    run_frame(0, 0);

    // Randomised maps
    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < C*R; i++)
        map_mem[i] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
      run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a render window aborts the frame without a done pulse
    map_mem[0] = 8'd3; map_mem[1] = 8'd5; map_mem[2] = 8'd7; map_mem[3] = 8'd9;
    model(lat);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (render_active) begin
        seen = 1;
        break;
      end
    end
    chk("render_seen_before_reset", seen, 1);
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1 chk_all_zero("midreset");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_active", render_active, 0);
    chk("post_reset_map_addr", map_addr, 0);

    run_frame(0, 0);

    repeat (4) @(negedge clk);
    chk("tiles_outstanding", exp_q.size(), 0);
    chk("dones_outstanding", done_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/tilemap_scheduler.md
Name: tilemap_scheduler

Overview:
Upstream sequencer for the 32x32 tile renderer. On a start request it walks a MAP_COLS x MAP_ROWS tile map held in a synchronous map ROM/RAM, row-major order. For each map entry it drives the renderer's tile_addr/top/left and a per-tile active-low restart. It then holds those values for exactly TILE_CYCLES cycles, the renderer's full 1024-pixel pass. Entries equal to SKIP_IDX (empty cells) are not rendered.

Parameters:
MAP_COLS, 20, tiles per row (640/32)
MAP_ROWS, 15, tile rows (480/32)
MAP_AW, 9, map address width; must satisfy 2^MAP_AW >= MAP_COLS*MAP_ROWS
TILE_CYCLES, 4096, cycles granted per tile (4 cycles/pixel x 1024 pixels)
SKIP_IDX, 8'hFF, tile index meaning "empty, do not render"

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
start  in  1  single-cycle request to render one full map; ignored while busy
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse after the last map entry is finished
map_addr  out  MAP_AW  map read address = row*MAP_COLS + col, registered
map_data  in  8  tile index; valid exactly 1 cycle after map_addr changes (sync read)
tile_addr  out  19  tile ROM base = map_data << 10 (zero-extended, 8+10 bits fits 19)
top  out  10  row*32
left  out  10  col*32
tile_rstn  out  1  renderer restart, active-low; high only while a tile renders
render_active  out  1  high during the TILE_CYCLES render window; gates renderer dst_wr downstream

Behaviour:
- Reset state (async, immediate): state=IDLE, busy=0, done=0, map_addr=0, tile_addr=0, top=0, left=0, tile_rstn=0, render_active=0, col=row=0, cycle counter=0.
- Reset mid-operation aborts the frame. No done pulse. Renderer is held in restart (tile_rstn=0).
- States:
  - IDLE: start=1 -> FETCH; clear col/row; map_addr<=0; busy<=1.
  - FETCH (1 cycle): map_addr holds row*MAP_COLS+col -> WAIT.
  - WAIT (1 cycle): map_data valid at end of cycle -> LOAD.
  - LOAD (1 cycle):
    - map_data==SKIP_IDX: -> ADVANCE. tile_addr/top/left are not updated.
    - Otherwise: tile_addr<=map_data<<10, top<=row*32, left<=col*32, counter<=0 -> RENDER.
  - RENDER: tile_rstn=1, render_active=1 for exactly TILE_CYCLES cycles. Counter counts 0..TILE_CYCLES-1; at TILE_CYCLES-1 -> ADVANCE. tile_addr/top/left remain stable throughout.
  - ADVANCE (1 cycle):
    - col==MAP_COLS-1 and row==MAP_ROWS-1 -> DONE.
    - else col==MAP_COLS-1: col<=0, row<=row+1.
    - else col<=col+1.
    - Non-final cases: map_addr<=next index -> FETCH.
  - DONE (1 cycle): done=1, busy<=0 -> IDLE.
- tile_rstn and render_active are registered. They are 0 in every state except RENDER, so the renderer starts each tile at pixel (0,0) with its phase counter at 0.
- Per-tile cost:
  - non-skipped tile: 4 + TILE_CYCLES cycles (FETCH, WAIT, LOAD, RENDER, ADVANCE)
  - skipped tile: 4 cycles
- Frame latency, start sample edge to done high: 1 + N_render*(4+TILE_CYCLES) + N_skip*4 cycles.
- start while busy (including in the DONE cycle): ignored, not queued.
- start in the same cycle done is high: ignored. A new start is accepted only in IDLE.
- map_addr arithmetic: MAP_AW bits, no wrap within a legal map. top/left: 10 bits; max 14*32=448 and 19*32=608, no overflow.
- map_data is sampled only in LOAD. Changes on map_data at other times have no effect.

Test Plan:
- Reset values: assert rstn=0 mid-RENDER -> all outputs 0 in the same cycle. After release, stays IDLE until start.
- Small map (MAP_COLS=2, MAP_ROWS=2, TILE_CYCLES=8), indices {3,5,7,9}, start -> map_addr sequence 0,1,2,3. Per tile (tile_addr, top, left):
  - (3072,0,0)
  - (5120,0,32)
  - (7168,32,0)
  - (9216,32,32)
  - Each tile gets tile_rstn=1 for exactly 8 cycles. done pulses once, 1+4*12=49 cycles after start.
- Same map with index 1 = 8'hFF -> three render windows only; left=32/top=0 never driven; done after 1+3*12+4=41 cycles.
- start pulses while busy and coincident with done -> no restart, single done per accepted start. busy drops the cycle after done.
- Back-to-back frames: start the cycle after done returns to IDLE -> second frame is identical in timing and output values.
- Default params, all entries 0 -> 300 render windows of 4096 cycles; final tile top=448, left=608, map_addr=299.
